// File: rtl/sliding_xcorr_tdoa_pkg.sv
// Shared types and pair-index helpers for the sliding cross-correlator.
// Optional peak-lag (TDOA) output is enabled with XCORR_PEAK_EN.
package sliding_xcorr_tdoa_pkg;

   localparam int unsigned DEF_BITS_SAMPLE = 12;
   localparam int unsigned DEF_BITS_XCORR  = 2 * DEF_BITS_SAMPLE + $clog2(100);

   typedef logic signed [DEF_BITS_SAMPLE-1:0] sample_t;
   typedef logic signed [DEF_BITS_XCORR-1:0]  xcorr_t;

   typedef enum logic {FILL, FULL} fill_state_e;

   function automatic int unsigned num_pairs(input int unsigned nch);
      return nch * (nch - 1) / 2;
   endfunction

   function automatic int unsigned lag_w(input int unsigned max_lag);
      return (max_lag == 0) ? 1 : $clog2(2 * max_lag + 1);
   endfunction

   // Lexicographic (a<b) enumeration: pair p -> first channel
   function automatic int unsigned pair_a(input int unsigned nch, input int unsigned p);
      int unsigned idx;
      idx = 0;
      for (int unsigned a = 0; a < nch; a++)
         for (int unsigned b = a + 1; b < nch; b++) begin
            if (idx == p) return a;
            idx++;
         end
      return 0;
   endfunction

   function automatic int unsigned pair_b(input int unsigned nch, input int unsigned p);
      int unsigned idx;
      idx = 0;
      for (int unsigned a = 0; a < nch; a++)
         for (int unsigned b = a + 1; b < nch; b++) begin
            if (idx == p) return b;
            idx++;
         end
      return 1;
   endfunction

endpackage

// File: rtl/sliding_xcorr_tdoa_if.sv
// Sample-in / correlation-out bundle; slave side is the correlator.
// peakLag/peakValid are always present; driven only with XCORR_PEAK_EN.
interface sliding_xcorr_tdoa_if #(
   parameter int unsigned NUM_CH          = 4,
   parameter int unsigned NUM_BITS_SAMPLE = 12,
   parameter int unsigned NUM_SAMPLES     = 100,
   parameter int unsigned MAX_LAG         = 11,
   parameter int unsigned NUM_BITS_XCORR  = 2 * NUM_BITS_SAMPLE + $clog2(NUM_SAMPLES)
) ();
   import sliding_xcorr_tdoa_pkg::*;

   localparam int unsigned NUM_PAIRS = num_pairs(NUM_CH);
   localparam int unsigned NL        = 2 * MAX_LAG + 1;
   localparam int unsigned LW        = lag_w(MAX_LAG);

   logic                              validIn;
   logic signed [NUM_BITS_SAMPLE-1:0] dataIn   [NUM_CH];
   logic signed [NUM_BITS_XCORR-1:0]  xCorrOut [NUM_PAIRS][NL];
   logic                              validOut;
   logic                              windowFull;
   logic        [LW-1:0]              peakLag  [NUM_PAIRS];
   logic                              peakValid;

   modport master (
      output validIn, dataIn,
      input  xCorrOut, validOut, windowFull, peakLag, peakValid
   );

   modport slave (
      input  validIn, dataIn,
      output xCorrOut, validOut, windowFull, peakLag, peakValid
   );

endinterface

// File: rtl/sliding_xcorr_tdoa_pair_lane.sv
// One channel pair: 2L+1 product registers, running accumulators and,
// with XCORR_PEAK_EN, a registered argmax over lags (ties -> lowest index).
module xcorr_pair_lane
   import sliding_xcorr_tdoa_pkg::*;
#(
   parameter int unsigned NUM_BITS_SAMPLE = 12,
   parameter int unsigned MAX_LAG         = 11,
   parameter int unsigned NUM_BITS_XCORR  = 31
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_prod_en,
   input  logic                              i_acc_en,
`ifdef XCORR_PEAK_EN
   input  logic                              i_peak_en,
`endif
   input  logic signed [NUM_BITS_SAMPLE-1:0] i_a_new,
   input  logic signed [NUM_BITS_SAMPLE-1:0] i_a_old,
   input  logic signed [NUM_BITS_SAMPLE-1:0] i_b_new [2*MAX_LAG+1],
   input  logic signed [NUM_BITS_SAMPLE-1:0] i_b_old [2*MAX_LAG+1],
`ifdef XCORR_PEAK_EN
   output logic [lag_w(MAX_LAG)-1:0]         o_peak_lag,
`endif
   output logic signed [NUM_BITS_XCORR-1:0]  o_xcorr [2*MAX_LAG+1]
);
   localparam int unsigned NL = 2 * MAX_LAG + 1;
   localparam int unsigned PW = 2 * NUM_BITS_SAMPLE;

   logic signed [PW-1:0]             r_prod_new [NL];
   logic signed [PW-1:0]             r_prod_old [NL];
   logic signed [NUM_BITS_XCORR-1:0] r_acc      [NL];

   // Operands widened first so the product is the exact signed result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned j = 0; j < NL; j++) begin
            r_prod_new[j] <= '0;
            r_prod_old[j] <= '0;
         end
      end else if (i_prod_en) begin
         for (int unsigned j = 0; j < NL; j++) begin
            r_prod_new[j] <= PW'(i_a_new) * PW'(i_b_new[j]);
            r_prod_old[j] <= PW'(i_a_old) * PW'(i_b_old[j]);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned j = 0; j < NL; j++) r_acc[j] <= '0;
      end else if (i_acc_en) begin
         for (int unsigned j = 0; j < NL; j++)
            r_acc[j] <= r_acc[j] + NUM_BITS_XCORR'(r_prod_new[j])
                                 - NUM_BITS_XCORR'(r_prod_old[j]);
      end
   end

   assign o_xcorr = r_acc;

`ifdef XCORR_PEAK_EN
   localparam int unsigned LW = lag_w(MAX_LAG);

   logic        [LW-1:0]             w_best_idx;
   logic signed [NUM_BITS_XCORR-1:0] w_best_val;
   logic        [LW-1:0]             r_peak_lag;

   always_comb begin
      w_best_idx = '0;
      w_best_val = r_acc[0];
      for (int unsigned j = 1; j < NL; j++) begin
         if (r_acc[j] > w_best_val) begin
            w_best_val = r_acc[j];
            w_best_idx = LW'(j);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            r_peak_lag <= '0;
      else if (i_peak_en) r_peak_lag <= w_best_idx;
   end

   assign o_peak_lag = r_peak_lag;
`endif

endmodule

// File: rtl/sliding_xcorr_tdoa.sv
// Sliding-window cross-correlator for all channel pairs over lags -L..+L.
// Optional per-pair peak lag enabled with XCORR_PEAK_EN.
module sliding_xcorr_tdoa
   import sliding_xcorr_tdoa_pkg::*;
#(
   parameter int unsigned NUM_CH          = 4,
   parameter int unsigned NUM_BITS_SAMPLE = 12,
   parameter int unsigned NUM_SAMPLES     = 100,
   parameter int unsigned MAX_LAG         = 11,
   parameter int unsigned NUM_BITS_XCORR  = 2 * NUM_BITS_SAMPLE + $clog2(NUM_SAMPLES)
) (
   input  logic                  clk,
   input  logic                  rst,
   sliding_xcorr_tdoa_if.slave   io_xc
);
   localparam int unsigned NUM_PAIRS = num_pairs(NUM_CH);
   localparam int unsigned NL        = 2 * MAX_LAG + 1;
   localparam int unsigned HD        = NUM_SAMPLES + 2 * MAX_LAG;
   localparam int unsigned CW        = $clog2(HD + 1);

   // r_hist[c][d] holds x_c[t-d]; index 0 is the most recently accepted sample
   logic signed [NUM_BITS_SAMPLE-1:0] r_hist [NUM_CH][HD+1];

   logic              r_vld_hist;
   logic              r_vld_prod;
   logic              r_valid_out;
   logic              r_window_full;
   logic [CW-1:0]     r_fill_cnt;
   fill_state_e       r_state;

   logic signed [NUM_BITS_XCORR-1:0] w_xcorr [NUM_PAIRS][NL];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned c = 0; c < NUM_CH; c++)
            for (int unsigned d = 0; d <= HD; d++) r_hist[c][d] <= '0;
      end else if (io_xc.validIn) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            r_hist[c][0] <= io_xc.dataIn[c];
            for (int unsigned d = 1; d <= HD; d++) r_hist[c][d] <= r_hist[c][d-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_hist    <= 1'b0;
         r_vld_prod    <= 1'b0;
         r_valid_out   <= 1'b0;
         r_window_full <= 1'b0;
         r_fill_cnt    <= '0;
         r_state       <= FILL;
      end else begin
         r_vld_hist  <= io_xc.validIn;
         r_vld_prod  <= r_vld_hist;
         r_valid_out <= r_vld_prod;
         // Fill count tracks samples already folded into the accumulators
         if (r_vld_prod) begin
            case (r_state)
               FILL: begin
                  if (r_fill_cnt == CW'(HD - 1)) begin
                     r_fill_cnt    <= CW'(HD);
                     r_window_full <= 1'b1;
                     r_state       <= FULL;
                  end else begin
                     r_fill_cnt <= r_fill_cnt + 1'b1;
                  end
               end
               FULL: r_state <= FULL;
               default: r_state <= FILL;
            endcase
         end
      end
   end

`ifdef XCORR_PEAK_EN
   logic                      r_peak_valid;
   logic [lag_w(MAX_LAG)-1:0] w_peak_lag [NUM_PAIRS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_peak_valid <= 1'b0;
      else     r_peak_valid <= r_valid_out;
   end

   assign io_xc.peakValid = r_peak_valid;
   assign io_xc.peakLag   = w_peak_lag;
`else
   assign io_xc.peakValid = 1'b0;
   for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_peak_tie
      assign io_xc.peakLag[p] = '0;
   end
`endif

   // a uses lag-centre taps; b supplies 2L+1 taps at the new and old window edges
   for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_lane
      localparam int unsigned PA = pair_a(NUM_CH, p);
      localparam int unsigned PB = pair_b(NUM_CH, p);

      logic signed [NUM_BITS_SAMPLE-1:0] w_b_new [NL];
      logic signed [NUM_BITS_SAMPLE-1:0] w_b_old [NL];

      for (genvar j = 0; j < NL; j++) begin : g_tap
         assign w_b_new[j] = r_hist[PB][j];
         assign w_b_old[j] = r_hist[PB][NUM_SAMPLES + j];
      end

      xcorr_pair_lane #(
         .NUM_BITS_SAMPLE (NUM_BITS_SAMPLE),
         .MAX_LAG         (MAX_LAG),
         .NUM_BITS_XCORR  (NUM_BITS_XCORR)
      ) u_lane (
         .clk        (clk),
         .rst        (rst),
         .i_prod_en  (r_vld_hist),
         .i_acc_en   (r_vld_prod),
`ifdef XCORR_PEAK_EN
         .i_peak_en  (r_valid_out),
`endif
         .i_a_new    (r_hist[PA][MAX_LAG]),
         .i_a_old    (r_hist[PA][MAX_LAG + NUM_SAMPLES]),
         .i_b_new    (w_b_new),
         .i_b_old    (w_b_old),
`ifdef XCORR_PEAK_EN
         .o_peak_lag (w_peak_lag[p]),
`endif
         .o_xcorr    (w_xcorr[p])
      );
   end

   assign io_xc.xCorrOut   = w_xcorr;
   assign io_xc.validOut   = r_valid_out;
   assign io_xc.windowFull = r_window_full;

endmodule

// File: tb/tb_sliding_xcorr_tdoa.sv
// Scoreboard bench: a windowed-sum reference model predicts every result;
// a monitor pops and compares whenever validOut / peakValid pulse.
module tb_sliding_xcorr_tdoa;
   import sliding_xcorr_tdoa_pkg::*;

   localparam int NUM_CH = 4;
   localparam int S      = 12;
   localparam int N      = 100;
   localparam int L      = 11;
   localparam int W      = 2 * S + $clog2(N);
   localparam int NP     = NUM_CH * (NUM_CH - 1) / 2;
   localparam int NL     = 2 * L + 1;
   localparam int LW     = $clog2(NL);
   localparam int HD     = N + 2 * L;

   typedef logic [NUM_CH-1:0][S-1:0] samp_t;
   typedef logic [NP-1:0][LW-1:0]    peak_t;
   typedef struct packed {
      logic [NP-1:0][NL-1:0][W-1:0] xc;
      logic                         wf;
      peak_t                        pk;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sliding_xcorr_tdoa_if #(
      .NUM_CH(NUM_CH), .NUM_BITS_SAMPLE(S), .NUM_SAMPLES(N), .MAX_LAG(L), .NUM_BITS_XCORR(W)
   ) xc ();

   sliding_xcorr_tdoa #(
      .NUM_CH(NUM_CH), .NUM_BITS_SAMPLE(S), .NUM_SAMPLES(N), .MAX_LAG(L), .NUM_BITS_XCORR(W)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .io_xc (xc)
   );

   exp_t  exp_q  [$];
   peak_t pk_q   [$];
   samp_t samp_q [$];
   int    checks = 0;
   int    errors = 0;
   int    popped = 0;
   int    pa [NP];
   int    pb [NP];

   function automatic longint xs(input int c, input int n);
      if (n < 0 || n >= samp_q.size()) return 0;
      return longint'($signed(samp_q[n][c]));
   endfunction

   // Direct evaluation of sum a[n]*b[n-k] over the N-sample window ending at t-L
   task automatic model_push();
      exp_t   e;
      int     t;
      longint sum, best;
      t = samp_q.size() - 1;
      e = '0;
      for (int p = 0; p < NP; p++) begin
         best = 0;
         for (int j = 0; j < NL; j++) begin
            sum = 0;
            for (int n = t - L - N + 1; n <= t - L; n++)
               sum += xs(pa[p], n) * xs(pb[p], n - (j - L));
            e.xc[p][j] = W'(sum);
            if (j == 0 || sum > best) begin
               best = sum;
               e.pk[p] = LW'(j);
            end
         end
      end
      e.wf = (samp_q.size() >= HD);
      exp_q.push_back(e);
   endtask

   task automatic send(input samp_t v);
      for (int c = 0; c < NUM_CH; c++) xc.dataIn[c] = $signed(v[c]);
      xc.validIn = 1'b1;
      samp_q.push_back(v);
      model_push();
      @(posedge clk);
      #1;
      xc.validIn = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_val(input string name, input longint got, input longint want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   task automatic check_zero(input string name);
      int bad;
      bad = 0;
      for (int p = 0; p < NP; p++) begin
         for (int j = 0; j < NL; j++) if (xc.xCorrOut[p][j] !== '0) bad++;
         if (xc.peakLag[p] !== '0) bad++;
      end
      if (xc.validOut !== 1'b0 || xc.windowFull !== 1'b0 || xc.peakValid !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s: %0d output fields nonzero, expected all zero (validOut=%b windowFull=%b peakValid=%b)",
                  name, bad, xc.validOut, xc.windowFull, xc.peakValid);
      end
   endtask

   task automatic do_reset(input string name);
      xc.validIn = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      pk_q.delete();
      samp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      check_zero(name);
      rst = 1'b0;
   endtask

   task automatic drain(input string name);
      idle(6);
      checks++;
      if (exp_q.size() != 0 || pk_q.size() != 0) begin
         errors++;
         $display("FAIL %s drain: %0d results and %0d peaks outstanding, expected 0",
                  name, exp_q.size(), pk_q.size());
      end
   endtask

   function automatic samp_t rnd_samp();
      samp_t r;
      for (int c = 0; c < NUM_CH; c++) r[c] = S'($urandom_range(0, 4095));
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
`ifdef XCORR_PEAK_EN
         if (xc.peakValid) begin
            peak_t ap, ep;
            checks++;
            for (int p = 0; p < NP; p++) ap[p] = xc.peakLag[p];
            if (pk_q.size() == 0) begin
               errors++;
               $display("FAIL stale_peak: peakValid=1 with no result pending, expected 0");
            end else begin
               ep = pk_q.pop_front();
               if (ap !== ep) begin
                  errors++;
                  $display("FAIL peak_lag: got %h expected %h", ap, ep);
               end
            end
         end
`else
         if (xc.validOut) begin
            int bad;
            bad = (xc.peakValid !== 1'b0) ? 1 : 0;
            for (int p = 0; p < NP; p++) if (xc.peakLag[p] !== '0) bad++;
            checks++;
            if (bad != 0) begin
               errors++;
               $display("FAIL peak_tied: %0d peak fields nonzero, expected 0", bad);
            end
         end
`endif
         if (xc.validOut) begin
            exp_t e, a;
            checks++;
            a = '0;
            for (int p = 0; p < NP; p++)
               for (int j = 0; j < NL; j++) a.xc[p][j] = xc.xCorrOut[p][j];
            a.wf = xc.windowFull;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL stale_valid: validOut=1 with no sample pending, expected 0");
            end else begin
               e = exp_q.pop_front();
               popped++;
`ifdef XCORR_PEAK_EN
               pk_q.push_back(e.pk);
`endif
               if (a.xc !== e.xc || a.wf !== e.wf) begin
                  int fp, fj;
                  fp = 0; fj = 0;
                  for (int p = NP - 1; p >= 0; p--)
                     for (int j = NL - 1; j >= 0; j--)
                        if (a.xc[p][j] !== e.xc[p][j]) begin fp = p; fj = j; end
                  errors++;
                  $display("FAIL result %0d: xCorrOut[%0d][%0d] got %0d expected %0d, windowFull got %b expected %b",
                           popped, fp, fj, $signed(a.xc[fp][fj]), $signed(e.xc[fp][fj]), a.wf, e.wf);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      samp_t  v;
      samp_t  rnd [200];
      xcorr_t sv;
      begin
         int idx;
         idx = 0;
         for (int a = 0; a < NUM_CH; a++)
            for (int b = a + 1; b < NUM_CH; b++) begin
               pa[idx] = a; pb[idx] = b; idx++;
            end
      end
      xc.validIn = 1'b0;
      for (int c = 0; c < NUM_CH; c++) xc.dataIn[c] = '0;
      #1;
      do_reset("reset_state");

      // Impulse: ch0 at t0, ch1 at t0+3 -> pair0 lag -3 (j=8)
      v = '0; v[0] = S'(100);
      send(v);
      v = '0;
      send(v); send(v);
      v[1] = S'(100);
      send(v);
      v = '0;
      for (int i = 0; i < 16; i++) send(v);
      drain("impulse");
      check_val("impulse_j8", longint'($signed(xc.xCorrOut[0][8])), 10000);
      check_val("impulse_j7", longint'($signed(xc.xCorrOut[0][7])), 0);
`ifdef XCORR_PEAK_EN
      check_val("impulse_peak", longint'(xc.peakLag[0]), 8);
`endif
      for (int i = 0; i < HD; i++) send(v);
      drain("impulse_flush");
      check_val("impulse_cleared", longint'($signed(xc.xCorrOut[0][8])), 0);

      // DC ones: windowFull rises exactly with sample N+2L
      do_reset("reset_dc");
      for (int c = 0; c < NUM_CH; c++) v[c] = S'(1);
      for (int i = 0; i < HD - 1; i++) send(v);
      drain("dc_pre");
      check_val("dc_wf_before", longint'(xc.windowFull), 0);
      send(v);
      drain("dc_full");
      check_val("dc_wf_at_full", longint'(xc.windowFull), 1);
      check_val("dc_lo", longint'($signed(xc.xCorrOut[0][0])), 100);
      check_val("dc_hi", longint'($signed(xc.xCorrOut[NP-1][NL-1])), 100);

      // Extreme-magnitude single aligned sample
      do_reset("reset_sign");
      v = '0; v[0] = S'(-2048); v[1] = S'(2047);
      send(v);
      v = '0;
      for (int i = 0; i < L; i++) send(v);
      drain("sign");
      sv = W'(-4192256);
      check_val("sign_j11", longint'($signed(xc.xCorrOut[0][L])), longint'(sv));

      // Random data back-to-back, then the same data with gaps
      for (int i = 0; i < 200; i++) rnd[i] = rnd_samp();
      do_reset("reset_b2b");
      for (int i = 0; i < 200; i++) send(rnd[i]);
      drain("random_b2b");
      do_reset("reset_gaps");
      for (int i = 0; i < 200; i++) begin
         while ($urandom_range(0, 99) >= 30) idle(1);
         send(rnd[i]);
      end
      drain("random_gaps");

      // Reset with samples still in the pipeline
      do_reset("reset_pre_mid");
      for (int i = 0; i < 42; i++) send(rnd_samp());
      do_reset("reset_mid");
      idle(6);
      check_zero("post_mid_reset");
      for (int i = 0; i < 20; i++) send(rnd_samp());
      drain("restart");

      idle(4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
